tx_gear_nx: RTL



---
 rtl/tx_gear_nx_pkg.sv | 38 +++
 rtl/tx_gear_nx_rf.sv | 28 ++
 rtl/tx_gear_nx.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/tx_gear_nx_pkg.sv
// Shared state encoding, parameter checks and helpers for the tx_gear_nx
// transmit gearbox.
package tx_gear_nx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam int MAX_GWIDTH = 64;
    localparam int HOLD_W     = 8;

    // Bit n of this mask is set when RATIO = n is supported.
    localparam int LEGAL_RATIO_MASK = 32'h0000_0014;

    function automatic int clog2_f(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic bit ratio_is_legal(input int ratio);
        return (ratio > 0) && (ratio < 32) && (((LEGAL_RATIO_MASK >> ratio) & 1) == 1);
    endfunction

    function automatic logic [MAX_GWIDTH-1:0] idle_word(input int gwidth, input int ei_bit);
        logic [MAX_GWIDTH-1:0] w;
        w = (ei_bit < gwidth) ? (64'd1 << ei_bit) : '0;
        return w;
    endfunction

endpackage

// File: rtl/tx_gear_nx_rf.sv
// Elastic word store for tx_gear_nx: one write port, one combinational read
// port, storage not reset.
module tx_gear_nx_rf
    import tx_gear_nx_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20,
    parameter int AW    = clog2_f(DEPTH)
) (
    input  logic             clk_250,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_250) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/tx_gear_nx.sv
// PCIe PHY TX gearbox: buffers wide words and emits one GWIDTH slice per lane
// per clk_250 cycle. Define TX_GEAR_NX_STATUS_EN to expose fill/ovf/unf.
module tx_gear_nx
    import tx_gear_nx_pkg::*;
#(
    parameter int GWIDTH  = 10,
    parameter int RATIO   = 2,
    parameter int LANES   = 1,
    parameter int DEPTH   = 4,
    parameter int HOLDOFF = 8,
    parameter int EI_BIT  = 9
) (
    input  logic                          clk_250,
    input  logic                          rst_n,
    input  logic                          drate_enable,
    input  logic                          in_valid,
    input  logic [LANES*RATIO*GWIDTH-1:0] data_in,
    output logic [LANES*GWIDTH-1:0]       data_out,
    output logic                          out_valid,
    output logic [clog2_f(DEPTH):0]       fill,
    output logic                          ovf,
    output logic                          unf
);

    localparam int  AW       = clog2_f(DEPTH);
    localparam int  FW       = AW + 1;
    localparam int  SW       = clog2_f(RATIO);
    localparam int  WW       = LANES * RATIO * GWIDTH;
    localparam bit  RATIO_OK = ratio_is_legal(RATIO);

    localparam logic [GWIDTH-1:0]       IW        = GWIDTH'(idle_word(GWIDTH, EI_BIT));
    localparam logic [LANES*GWIDTH-1:0] IDLE_OUT  = {LANES{IW}};
    localparam logic [SW-1:0]           SL_LAST   = SW'(RATIO - 1);
    localparam logic [HOLD_W-1:0]       HOLD_LAST = HOLD_W'(HOLDOFF - 1);
    localparam logic [FW-1:0]           FILL_MAX  = FW'(DEPTH);

    if (!RATIO_OK) begin : g_bad_ratio
        $error("tx_gear_nx: RATIO must be 2 or 4");
    end

    state_t                   state_q, state_d;
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]            fill_q, fill_d;
    logic [SW-1:0]            sl_idx_q, sl_idx_d;
    logic [HOLD_W-1:0]        hold_q, hold_d;
    logic [LANES*GWIDTH-1:0]  data_out_q, data_out_d;
    logic                     out_valid_q, out_valid_d;

    logic                     push_req;
    logic                     push;
    logic                     pop;
    logic                     full;
    logic                     underflow;
    logic [WW-1:0]            rd_word;
    logic [LANES*GWIDTH-1:0]  run_word;

    tx_gear_nx_rf #(
        .DEPTH (DEPTH),
        .WIDTH (WW),
        .AW    (AW)
    ) u_rf (
        .clk_250 (clk_250),
        .we      (push),
        .waddr   (wr_ptr_q),
        .wdata   (data_in),
        .raddr   (rd_ptr_q),
        .rdata   (rd_word)
    );

    // All lanes share sl_idx, so they always present the same slice number.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [GWIDTH-1:0] slices [RATIO];
        for (genvar k = 0; k < RATIO; k++) begin : g_slice
            assign slices[k] = rd_word[(l*RATIO + k)*GWIDTH +: GWIDTH];
        end
        assign run_word[l*GWIDTH +: GWIDTH] = slices[sl_idx_q];
    end

    assign full      = (fill_q == FILL_MAX);
    assign underflow = (state_q == ST_RUN) && (sl_idx_q == '0) && (fill_q == '0);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        sl_idx_d    = sl_idx_q;
        hold_d      = hold_q;
        data_out_d  = IDLE_OUT;
        out_valid_d = 1'b0;
        push_req    = 1'b0;
        pop         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (drate_enable) begin
                    state_d = ST_PRIME;
                    hold_d  = '0;
                end
            end
            ST_PRIME: begin
                push_req = in_valid;
                if (hold_q != '1) begin
                    hold_d = hold_q + 1'b1;
                end
                if ((hold_q >= HOLD_LAST) && (fill_q >= FW'(2))) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                push_req = in_valid;
                if (underflow) begin
                    state_d = ST_PRIME;
                    hold_d  = '0;
                end else begin
                    data_out_d  = run_word;
                    out_valid_d = 1'b1;
                    if (sl_idx_q == SL_LAST) begin
                        sl_idx_d = '0;
                        pop      = 1'b1;
                    end else begin
                        sl_idx_d = sl_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A pop in the same cycle frees the slot, so a full buffer still accepts.
        push = push_req && (!full || pop);
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        fill_d = fill_q + FW'(push) - FW'(pop);

        if (!drate_enable) begin
            state_d  = ST_IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
            sl_idx_d = '0;
            hold_d   = '0;
        end
    end

    always_ff @(posedge clk_250 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            sl_idx_q    <= '0;
            hold_q      <= '0;
            data_out_q  <= IDLE_OUT;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            sl_idx_q    <= sl_idx_d;
            hold_q      <= hold_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;

`ifdef TX_GEAR_NX_STATUS_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    // Flags are sticky until the next IDLE->PRIME entry.
    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if ((state_q == ST_IDLE) && drate_enable) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else begin
            if (push_req && full && !pop) begin
                ovf_d = 1'b1;
            end
            if (underflow) begin
                unf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_250 or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign ovf  = ovf_q;
    assign unf  = unf_q;
    assign fill = fill_q;
`else
    assign ovf  = 1'b0;
    assign unf  = 1'b0;
    assign fill = '0;
`endif

endmodule
